// File: rtl/booth_datapath.sv
// booth_datapath: register and arithmetic half of the radix-2 Booth signed multiplier.
// Holds M, A (W+1 bits), Q and Q_m1, obeys the controller's per-register commands,
// hands the Booth pair {Q[0],Q_m1} back as Q_in, captures the 2W-bit product and
// raises a sticky flag whenever the controller asks for only half of a shift.
module booth_datapath #(
  parameter int W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [W-1:0]     multiplicand,
  input  logic [W-1:0]     multiplier,
  input  logic [1:0]       Q_sig,
  input  logic [1:0]       A_sig,
  input  logic             M_sig,
  input  logic             adder_sig,
  input  logic             done_sig,
  output logic [1:0]       Q_in,
  output logic [2*W-1:0]   product,
  output logic             product_valid,
  output logic             protocol_err
);

  // Q register command encoding
  typedef enum logic [1:0] {
    Q_HOLD   = 2'b00,
    Q_SHIFT  = 2'b01,
    Q_LOAD   = 2'b10,
    Q_HOLD_B = 2'b11
  } q_cmd_t;

  // A register command encoding
  typedef enum logic [1:0] {
    A_HOLD  = 2'b00,
    A_SHIFT = 2'b01,
    A_CLEAR = 2'b10,
    A_SUM   = 2'b11
  } a_cmd_t;

  q_cmd_t q_cmd;
  a_cmd_t a_cmd;

  // A carries one extra sign bit so that subtracting M = -2^(W-1) cannot overflow
  logic [W:0]       a_reg;
  logic [W:0]       a_next;
  logic [W-1:0]     q_reg;
  logic [W-1:0]     q_next;
  logic             q_m1_reg;
  logic             q_m1_next;
  logic [W-1:0]     m_reg;
  logic [W-1:0]     m_next;
  logic [W:0]       m_ext;
  logic [W:0]       sum;
  logic [2*W-1:0]   product_reg;
  logic [2*W-1:0]   product_next;
  logic             valid_reg;
  logic             valid_next;
  logic             err_reg;
  logic             err_next;
  logic             q_shift;
  logic             a_shift;

  assign q_cmd   = q_cmd_t'(Q_sig);
  assign a_cmd   = a_cmd_t'(A_sig);
  assign q_shift = (q_cmd == Q_SHIFT);
  assign a_shift = (a_cmd == A_SHIFT);

  // Sign-extend M to the A width and form A+M or A-M; the carry out is simply dropped
  always_comb begin
    m_ext = {m_reg[W-1], m_reg};
    sum   = '0;
    if (adder_sig) begin
      sum = a_reg - m_ext;
    end else begin
      sum = a_reg + m_ext;
    end
  end

  // Next value of A: hold, arithmetic shift right, clear, or take the adder result
  always_comb begin
    a_next = a_reg;
    case (a_cmd)
      A_HOLD:  a_next = a_reg;
      A_SHIFT: a_next = {a_reg[W], a_reg[W:1]};
      A_CLEAR: a_next = '0;
      A_SUM:   a_next = sum;
      default: a_next = a_reg;
    endcase
  end

  // Next value of Q and Q_m1: the shift pulls A's old LSB into Q's MSB
  always_comb begin
    q_next    = q_reg;
    q_m1_next = q_m1_reg;
    case (q_cmd)
      Q_SHIFT: begin
        q_next    = {a_reg[0], q_reg[W-1:1]};
        q_m1_next = q_reg[0];
      end
      Q_LOAD: begin
        q_next    = multiplier;
        q_m1_next = 1'b0;
      end
      default: begin
        q_next    = q_reg;
        q_m1_next = q_m1_reg;
      end
    endcase
  end

  // Next value of M: load the multiplicand when asked, otherwise hold
  always_comb begin
    m_next = m_reg;
    if (M_sig) begin
      m_next = multiplicand;
    end
  end

  // Product capture and its valid flag; a new multiplier load invalidates but keeps the old value
  always_comb begin
    product_next = product_reg;
    valid_next   = valid_reg;
    if (done_sig) begin
      product_next = {a_reg[W-1:0], q_reg};
      valid_next   = 1'b1;
    end
    if (q_cmd == Q_LOAD) begin
      valid_next = 1'b0;
    end
  end

  // A shift must move A and Q together; either half alone latches the sticky error
  always_comb begin
    err_next = err_reg;
    if (q_shift != a_shift) begin
      err_next = 1'b1;
    end
  end

  // Arithmetic registers, cleared immediately by reset so no partial result survives
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_reg    <= '0;
      q_reg    <= '0;
      q_m1_reg <= 1'b0;
      m_reg    <= '0;
    end else begin
      a_reg    <= a_next;
      q_reg    <= q_next;
      q_m1_reg <= q_m1_next;
      m_reg    <= m_next;
    end
  end

  // Result and status registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      product_reg <= '0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      product_reg <= product_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
    end
  end

  assign Q_in          = {q_reg[0], q_m1_reg};
  assign product       = product_reg;
  assign product_valid = valid_reg;
  assign protocol_err  = err_reg;

endmodule
